// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Latency XLEN+2 cycles accept-to-done (1 for divide early-outs); ready_o is low while busy, flush_i aborts.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] srca_i,
  input  logic [XLEN-1:0] srcb_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_dvs;
  logic [2*XLEN-1:0]   r_prod;
  logic                r_neg_lo;
  logic                r_neg_rem;
  logic [XLEN-1:0]     r_result;

  logic                w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_a_mag, w_b_mag;
  logic                w_div0, w_ovf, w_early, w_accept;
  logic [XLEN-1:0]     w_early_res;
  logic [XLEN:0]       w_sum, w_shift, w_diff;
  logic [2*XLEN-1:0]   w_mul_step, w_div_step, w_prod_fix;
  logic [XLEN-1:0]     w_quo_fix, w_rem_fix, w_fix_res;

  // Operand decode happens only at accept time; afterwards only latched magnitudes are used.
  always_comb begin
    w_is_div = funct3_i[2];
    w_a_sgn  = w_is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10);
    w_b_sgn  = w_is_div ? ~funct3_i[0] : (funct3_i[1:0] == 2'b01);
    w_a_neg  = w_a_sgn & srca_i[XLEN-1];
    w_b_neg  = w_b_sgn & srcb_i[XLEN-1];
    w_a_mag  = w_a_neg ? -srca_i : srca_i;
    w_b_mag  = w_b_neg ? -srcb_i : srcb_i;
    w_div0   = (srcb_i == '0);
    w_ovf    = ~funct3_i[0] && (srca_i == MOST_NEG) && (srcb_i == ALL_ONES);
    w_early  = w_is_div & (w_div0 | w_ovf);
    if (w_div0) w_early_res = funct3_i[1] ? srca_i : ALL_ONES;
    else        w_early_res = funct3_i[1] ? '0 : srca_i;
  end

  // Multiply keeps the multiplier in the low half; divide keeps {remainder, quotient}.
  always_comb begin
    w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, (r_prod[0] ? r_dvs : '0)};
    w_mul_step = {w_sum, r_prod[XLEN-1:1]};
    w_shift    = r_prod[2*XLEN-1:XLEN-1];
    w_diff     = w_shift - {1'b0, r_dvs};
    w_div_step = w_diff[XLEN] ? {w_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                              : {w_diff[XLEN-1:0],  r_prod[XLEN-2:0], 1'b1};
  end

  always_comb begin
    w_prod_fix = r_neg_lo  ? -r_prod : r_prod;
    w_quo_fix  = r_neg_lo  ? -r_prod[XLEN-1:0] : r_prod[XLEN-1:0];
    w_rem_fix  = r_neg_rem ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];
    if (r_op[2])               w_fix_res = r_op[1] ? w_rem_fix : w_quo_fix;
    else if (r_op[1:0] == 2'b00) w_fix_res = w_prod_fix[XLEN-1:0];
    else                       w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_next   = r_state;
    ready_o  = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        ready_o  = 1'b1;
        done_o   = (r_state == S_DONE);
        w_accept = valid_i & ~flush_i;
        if (w_accept) w_next = w_early ? S_DONE : S_CALC;
        else          w_next = S_IDLE;
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (r_cnt == CNT_LAST) w_next = S_FIX;
      end
      S_FIX: begin
        busy_o = 1'b1;
        w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
    if (flush_i) w_next = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_dvs     <= '0;
      r_prod    <= '0;
      r_neg_lo  <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_op      <= funct3_i;
      r_dvs     <= w_is_div ? w_b_mag : w_a_mag;
      r_prod    <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
      r_neg_lo  <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      if (w_early) r_result <= w_early_res;
    end else if (r_state == S_CALC) begin
      r_prod <= r_op[2] ? w_div_step : w_mul_step;
      r_cnt  <= r_cnt + 1'b1;
    end else if (r_state == S_FIX && !flush_i) begin
      r_result <= w_fix_res;
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: a driver pushes expected results into a
// scoreboard queue at accept time and a negedge monitor pops on every done_o.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, valid, flush;
  logic [2:0]  f3;
  logic [31:0] a, b, res;
  logic        ready, busy, done;

  logic        rst64, valid64, flush64;
  logic [2:0]  f364;
  logic [63:0] a64, b64, res64;
  logic        ready64, busy64, done64;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .funct3_i(f3), .srca_i(a), .srcb_i(b),
    .flush_i(flush), .ready_o(ready), .busy_o(busy), .done_o(done), .result_o(res)
  );

  muldiv_unit #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst64), .valid_i(valid64), .funct3_i(f364), .srca_i(a64), .srcb_i(b64),
    .flush_i(flush64), .ready_o(ready64), .busy_o(busy64), .done_o(done64), .result_o(res64)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] q_res[$];
  int          q_lat[$];
  int          q_acc[$];
  string       q_nm[$];
  logic [63:0] q64_res[$];
  int          q64_acc[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] fn, input logic [31:0] opa,
                       input logic [31:0] opb, input logic [31:0] exp, input int lat,
                       input bit track);
    int k;
    k = 0;
    @(negedge clk);
    while (!ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ready) begin
      check({nm, " ready timeout"}, ready, 1);
      return;
    end
    f3 = fn; a = opa; b = opb; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    if (track) begin
      q_res.push_back(exp);
      q_lat.push_back(lat);
      q_acc.push_back(cyc);
      q_nm.push_back(nm);
    end
  endtask

  // Latency is counted with the accept cycle as 0 and the done cycle inclusive.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q_res.size() == 0) begin
        check("unexpected done_o", done, 0);
      end else begin
        string nm;
        logic [31:0] e;
        int l, t;
        nm = q_nm.pop_front();
        e  = q_res.pop_front();
        l  = q_lat.pop_front();
        t  = q_acc.pop_front();
        check(nm, res, e);
        check({nm, " latency"}, cyc - t + 1, l);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst64 && done64) begin
      if (q64_res.size() == 0) begin
        check("unexpected done64", done64, 0);
      end else begin
        logic [63:0] e;
        int t;
        e = q64_res.pop_front();
        t = q64_acc.pop_front();
        check("MULHU64", res64, e);
        check("MULHU64 latency", cyc - t + 1, 66);
      end
    end
  end

  initial begin
    rst64 = 1'b1; valid64 = 1'b0; flush64 = 1'b0; f364 = '0; a64 = '0; b64 = '0;
    repeat (3) @(negedge clk);
    rst64 = 1'b0;
    @(negedge clk);
    f364 = 3'b011; a64 = '1; b64 = '1; valid64 = 1'b1;
    @(posedge clk);
    #1;
    valid64 = 1'b0;
    q64_res.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    q64_acc.push_back(cyc);
  end

  initial begin
    int hi, t0, k;
    logic [31:0] saved;
    rst = 1'b1; valid = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset ready_o", ready, 1);
    check("reset busy_o", busy, 0);
    check("reset done_o", done, 0);
    check("reset result_o", res, 0);
    rst = 1'b0;

    issue("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1);
    hi = 0;
    repeat (33) begin
      @(negedge clk);
      if (ready) hi++;
    end
    check("MUL ready low cycles", hi, 0);
    @(negedge clk);
    @(negedge clk);
    check("MUL done pulse width", done, 0);

    issue("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1);
    issue("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1);
    issue("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1);

    issue("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1);
    t0 = cyc;
    issue("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1);
    check("back-to-back accept spacing", cyc - t0, 34);
    issue("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1);
    issue("REMU", 3'b111, 32'd100, 32'd7, 32'd2, 34, 1);

    issue("DIV by zero",  3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1);
    issue("DIV overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    issue("REM overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1);
    issue("REMU by zero", 3'b111, 32'd5, 32'd0, 32'd5, 1, 1);

    issue("MUL flushed", 3'b000, 32'd3, 32'd5, 32'd15, 34, 0);
    saved = 32'd5;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush ready_o", ready, 1);
    check("flush busy_o", busy, 0);
    check("flush result_o kept", res, saved);
    repeat (40) @(negedge clk);
    issue("DIVU after flush", 3'b101, 32'd9, 32'd3, 32'd3, 34, 1);

    k = 0;
    while (q_res.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    f3 = 3'b000; a = 32'd4; b = 32'd4; valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush+valid no accept busy_o", busy, 0);
    repeat (40) @(negedge clk);

    issue("MUL reset", 3'b000, 32'd2, 32'd3, 32'd6, 34, 0);
    repeat (5) @(negedge clk);
    check("pre-reset busy_o", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async reset ready_o", ready, 1);
    check("async reset busy_o", busy, 0);
    check("async reset done_o", done, 0);
    check("async reset result_o", res, 0);
    #1;
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue("MULHU after reset", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1, 34, 1);

    k = 0;
    while ((q_res.size() != 0 || q64_res.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard drained", q_res.size(), 0);
    check("scoreboard64 drained", q64_res.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
